// File: rtl/bfp_decomp_ctrl.sv
// Section sequencer for the BFP decompression datapath: latches the section
// configuration, frames input beats into PRBs and meters them with credits.
module bfp_decomp_ctrl #(
  parameter int BEATS_PER_PRB = 6,
  parameter int CREDITS       = 8,
  parameter int PIPE_LAT      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_num_prb,
  input  logic [3:0]  cmd_iq_width,
  input  logic [3:0]  cmd_fs_offset,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [63:0] din_data,
  output logic [3:0]  din_state,
  output logic        din_valid,
  output logic        din_sync,
  output logic        din_last,
  output logic [3:0]  ud_iq_width,
  output logic [3:0]  ctrl_fs_offset,
  input  logic        credit_return,
  output logic        done,
  output logic        err_len
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int DW = $clog2(PIPE_LAT + 2);
  localparam logic [3:0]    LAST_BEAT = 4'(BEATS_PER_PRB - 1);
  localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
  localparam logic [DW-1:0] DRAIN_END = DW'(PIPE_LAT);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] credit;
  logic [8:0]    num_prb;
  logic [8:0]    prb_cnt;
  logic [3:0]    beat_cnt;
  logic [DW-1:0] drain_cnt;

  logic cmd_fire, beat_fire, issue;
  logic final_beat, end_beat, len_err, drain_end;

  assign final_beat = (prb_cnt == num_prb - 9'd1) && (beat_cnt == LAST_BEAT);
  assign end_beat   = final_beat | s_axis_tlast;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    cmd_ready     = 1'b0;
    s_axis_tready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = RUN;
      end
      RUN: begin
        s_axis_tready = (credit != '0);
        // final beat without tlast means upstream is still sending: discard the rest
        if (s_axis_tvalid && credit != '0 && end_beat)
          state_nx = (final_beat && !s_axis_tlast) ? FLUSH : DRAIN;
      end
      FLUSH: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_nx = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_END) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign beat_fire = s_axis_tvalid & s_axis_tready;
  assign issue     = beat_fire & (state == RUN);
  assign len_err   = issue & (final_beat ^ s_axis_tlast);
  assign drain_end = (state == DRAIN) && (drain_cnt == DRAIN_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      ud_iq_width    <= '0;
      ctrl_fs_offset <= '0;
      num_prb        <= '0;
      prb_cnt        <= '0;
      beat_cnt       <= '0;
      din_data       <= '0;
      din_state      <= '0;
      din_valid      <= 1'b0;
      din_sync       <= 1'b0;
      din_last       <= 1'b0;
      err_len        <= 1'b0;
      done           <= 1'b0;
      drain_cnt      <= '0;
    end else begin
      if (cmd_fire) begin
        ud_iq_width    <= cmd_iq_width;
        ctrl_fs_offset <= cmd_fs_offset;
        num_prb        <= (cmd_num_prb == 8'd0) ? 9'd256 : {1'b0, cmd_num_prb};
        prb_cnt        <= '0;
        beat_cnt       <= '0;
      end
      din_valid <= issue;
      din_sync  <= issue && prb_cnt == '0 && beat_cnt == '0;
      din_last  <= issue && end_beat;
      err_len   <= len_err;
      done      <= drain_end;
      if (issue) begin
        din_data  <= s_axis_tdata;
        din_state <= beat_cnt;
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt <= '0;
          prb_cnt  <= prb_cnt + 9'd1;
        end else begin
          beat_cnt <= beat_cnt + 4'd1;
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
    end
  end

  // credit persists across sections; only reset refills it
  always_ff @(posedge clk) begin
    if (rst)
      credit <= CRED_MAX;
    else if (issue && !credit_return)
      credit <= credit - CW'(1);
    else if (!issue && credit_return && credit != CRED_MAX)
      credit <= credit + CW'(1);
  end

endmodule

// File: tb/tb_bfp_decomp_ctrl.sv
// Directed bench for bfp_decomp_ctrl with a beat-level reference model and
// per-cycle comparison of every output.
module tb_bfp_decomp_ctrl;

  localparam int BPP      = 6;
  localparam int CREDITS  = 8;
  localparam int PIPE_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_num_prb = '0;
  logic [3:0]  cmd_iq_width = '0;
  logic [3:0]  cmd_fs_offset = '0;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [63:0] din_data;
  logic [3:0]  din_state;
  logic        din_valid, din_sync, din_last;
  logic [3:0]  ud_iq_width, ctrl_fs_offset;
  logic        credit_return = 1'b0;
  logic        done, err_len;

  always #5 clk = ~clk;

  bfp_decomp_ctrl #(.BEATS_PER_PRB(BPP), .CREDITS(CREDITS), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_prb(cmd_num_prb),
    .cmd_iq_width(cmd_iq_width), .cmd_fs_offset(cmd_fs_offset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .din_data(din_data), .din_state(din_state), .din_valid(din_valid),
    .din_sync(din_sync), .din_last(din_last),
    .ud_iq_width(ud_iq_width), .ctrl_fs_offset(ctrl_fs_offset),
    .credit_return(credit_return), .done(done), .err_len(err_len)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference model: section as a flat beat count, mode 0 idle / 1 run / 2 flush / 3 drain.
  // e_* hold the outputs expected after the most recent clock edge.
  bit          m_ok = 0;
  int          m_mode, m_credit, m_n, m_total, m_drain;
  logic        e_valid, e_sync, e_last, e_err, e_done, e_cmd_ready, e_tready;
  logic [63:0] e_data;
  logic [3:0]  e_state, e_w, e_o;

  always @(posedge clk) begin
    bit fire, issued, fin;
    if (rst) begin
      m_ok = 1; m_mode = 0; m_credit = CREDITS;
      e_valid = 0; e_sync = 0; e_last = 0; e_err = 0; e_done = 0;
      e_data = '0; e_state = '0; e_w = '0; e_o = '0;
    end else begin
      fire   = s_axis_tvalid && e_tready;
      issued = 0;
      e_valid = 0; e_sync = 0; e_last = 0; e_err = 0; e_done = 0;
      case (m_mode)
        0: if (cmd_valid) begin
          e_w = cmd_iq_width;
          e_o = cmd_fs_offset;
          m_total = ((cmd_num_prb == 0) ? 256 : int'(cmd_num_prb)) * BPP;
          m_n = 0;
          m_mode = 1;
        end
        1: if (fire) begin
          issued  = 1;
          fin     = (m_n == m_total - 1);
          e_valid = 1;
          e_data  = s_axis_tdata;
          e_state = 4'(m_n % BPP);
          e_sync  = (m_n == 0);
          e_last  = fin || s_axis_tlast;
          e_err   = (fin != s_axis_tlast);
          if (fin && !s_axis_tlast) m_mode = 2;
          else if (e_last) begin m_mode = 3; m_drain = PIPE_LAT + 1; end
          m_n++;
        end
        2: if (fire && s_axis_tlast) begin m_mode = 3; m_drain = PIPE_LAT + 1; end
        default: begin
          m_drain--;
          if (m_drain == 0) begin e_done = 1; m_mode = 0; end
        end
      endcase
      if (issued && !credit_return) m_credit--;
      else if (!issued && credit_return && m_credit < CREDITS) m_credit++;
    end
    e_cmd_ready = (m_mode == 0);
    e_tready    = (m_mode == 1) ? (m_credit != 0) : (m_mode == 2);
  end

  int cyc = 0, n_valid = 0, n_sync = 0, n_last = 0, n_err = 0, n_done = 0;
  int last_cyc = 0, done_cyc = 0;
  logic [3:0] last_state = '0;

  always @(negedge clk) begin
    if (m_ok) begin
      cyc++;
      chk("din_valid", din_valid, e_valid);
      if (e_valid) begin
        chk("din_data", din_data, e_data);
        chk("din_state", din_state, e_state);
      end
      chk("din_sync", din_sync, e_sync);
      chk("din_last", din_last, e_last);
      chk("err_len", err_len, e_err);
      chk("done", done, e_done);
      chk("cmd_ready", cmd_ready, e_cmd_ready);
      chk("s_axis_tready", s_axis_tready, e_tready);
      chk("ud_iq_width", ud_iq_width, e_w);
      chk("ctrl_fs_offset", ctrl_fs_offset, e_o);
      if (din_valid) n_valid++;
      if (din_sync)  n_sync++;
      if (din_last) begin n_last++; last_cyc = cyc; last_state = din_state; end
      if (err_len)   n_err++;
      if (done) begin n_done++; done_cyc = cyc; end
    end
  end

  task automatic send_cmd(input logic [7:0] n, input logic [3:0] w, input logic [3:0] o);
    cmd_num_prb = n; cmd_iq_width = w; cmd_fs_offset = o; cmd_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cmd_ready) begin @(posedge clk); #1; cmd_valid = 1'b0; return; end
    end
    cmd_valid = 1'b0;
    timeout("cmd_handshake");
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l);
    s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        return;
      end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    timeout("beat_handshake");
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin @(posedge clk); #1; return; end
    end
    timeout("wait_done");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bv, bs, bl, be, bd;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_din_valid", din_valid, 1'b0);
    chk("rst_width", ud_iq_width, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // nominal two-PRB section, credits always returned
    credit_return = 1'b1;
    bv = n_valid; bs = n_sync; bl = n_last; be = n_err; bd = n_done;
    send_cmd(8'd2, 4'd9, 4'd3);
    for (int i = 0; i < 12; i++) send_beat(64'hA000 + 64'(i), i == 11);
    wait_done();
    chk("t1_beats", n_valid - bv, 12);
    chk("t1_sync", n_sync - bs, 1);
    chk("t1_last", n_last - bl, 1);
    chk("t1_err", n_err - be, 0);
    chk("t1_done_gap", done_cyc - last_cyc, 4);
    chk("t1_width", ud_iq_width, 4'd9);
    chk("t1_offset", ctrl_fs_offset, 4'd3);

    // credit exhaustion: 8 beats, then one more per returned credit
    credit_return = 1'b0;
    bv = n_valid; be = n_err;
    send_cmd(8'd2, 4'd4, 4'd0);
    s_axis_tdata = 64'hBEEF; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t2_stall_beats", n_valid - bv, 8);
    chk("t2_stall_tready", s_axis_tready, 1'b0);
    credit_return = 1'b1;
    @(posedge clk); #1;
    credit_return = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t2_one_more", n_valid - bv, 9);
    s_axis_tvalid = 1'b0;
    credit_return = 1'b1;
    send_beat(64'h1, 1'b0);
    send_beat(64'h2, 1'b0);
    send_beat(64'h3, 1'b1);
    wait_done();
    chk("t2_beats", n_valid - bv, 12);
    chk("t2_err", n_err - be, 0);

    // early tlast on beat 3 of a one-PRB section
    bv = n_valid; be = n_err; bd = n_done;
    send_cmd(8'd1, 4'd7, 4'd1);
    send_beat(64'hC0, 1'b0);
    send_beat(64'hC1, 1'b0);
    send_beat(64'hC2, 1'b1);
    wait_done();
    chk("t3_beats", n_valid - bv, 3);
    chk("t3_last_state", last_state, 4'd2);
    chk("t3_err", n_err - be, 1);
    chk("t3_done", n_done - bd, 1);

    // missing tlast: final beat issued, three extra beats flushed
    bv = n_valid; be = n_err; bd = n_done;
    send_cmd(8'd1, 4'd8, 4'd2);
    for (int i = 0; i < 9; i++) send_beat(64'hD0 + 64'(i), i == 8);
    wait_done();
    chk("t4_beats", n_valid - bv, 6);
    chk("t4_last_state", last_state, 4'd5);
    chk("t4_err", n_err - be, 1);
    chk("t4_done", n_done - bd, 1);

    // 256-PRB section with a stray command mid-way
    bv = n_valid; bl = n_last; be = n_err;
    send_cmd(8'd0, 4'd5, 4'd6);
    for (int i = 0; i < 1536; i++) begin
      if (i == 700) begin cmd_valid = 1'b1; cmd_iq_width = 4'd12; cmd_num_prb = 8'd3; end
      if (i == 705) cmd_valid = 1'b0;
      send_beat((64'(i) * 3) ^ 64'h5555_0000_5555, i == 1535);
    end
    wait_done();
    chk("t5_beats", n_valid - bv, 1536);
    chk("t5_last", n_last - bl, 1);
    chk("t5_err", n_err - be, 0);
    chk("t5_width", ud_iq_width, 4'd5);
    chk("t5_offset", ctrl_fs_offset, 4'd6);

    // reset mid-section
    credit_return = 1'b0;
    send_cmd(8'd2, 4'd11, 4'd9);
    for (int i = 0; i < 4; i++) send_beat(64'hE0 + 64'(i), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_cmd_ready", cmd_ready, 1'b1);
    chk("t6_tready", s_axis_tready, 1'b0);
    chk("t6_din_valid", din_valid, 1'b0);
    chk("t6_din_data", din_data, 64'h0);
    chk("t6_din_state", din_state, 4'd0);
    chk("t6_width", ud_iq_width, 4'd0);
    chk("t6_offset", ctrl_fs_offset, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bv = n_valid;
    send_cmd(8'd2, 4'd1, 4'd0);
    s_axis_tdata = 64'hF00D; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_credit_refill", n_valid - bv, 8);
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bfp_decomp_ctrl.md
Name: bfp_decomp_ctrl

Overview:
- Section-level sequencer in front of the BFP decompression datapath (`bfp_decomp_exp`, fixed latency 3).
- Accepts one section command at a time: width, fs offset, PRB count. Holds the datapath configuration stable for the whole section.
- Frames incoming 64-bit beats into PRBs, driving `din_state`, `din_sync` and `din_last`.
- Throttles input with a credit counter, because the datapath has no backpressure.

Parameters:
- BEATS_PER_PRB, 6: 64-bit beats per PRB (24 samples, 4 per beat); `din_state` counts 0..BEATS_PER_PRB-1.
- CREDITS, 8: entries of the downstream buffer after the datapath; maximum beats in flight.
- PIPE_LAT, 3: datapath latency in cycles; length of the DRAIN state.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  section command valid
- cmd_ready  out  1  command accepted when both valid and ready
- cmd_num_prb  in  8  PRBs in section; 0 means 256
- cmd_iq_width  in  4  mantissa width; 0 means 16
- cmd_fs_offset  in  4  extra shift for the datapath
- s_axis_tdata  in  64  aligned compressed beat
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted
- s_axis_tlast  in  1  upstream end-of-section marker
- din_data  out  64  registered copy of the accepted beat
- din_state  out  4  beat index within the PRB
- din_valid  out  1  beat valid to datapath
- din_sync  out  1  first beat of section
- din_last  out  1  final beat of section
- ud_iq_width  out  4  latched width
- ctrl_fs_offset  out  4  latched offset
- credit_return  in  1  downstream buffer freed one entry
- done  out  1  one-cycle pulse when a section is fully drained
- err_len  out  1  one-cycle pulse on a tlast/length mismatch

Behaviour:
- Reset values: state=IDLE, credit=CREDITS, all din_* = 0, ud_iq_width = 0, ctrl_fs_offset = 0, done = 0, err_len = 0, cmd_ready = 1.
- States: IDLE, RUN, FLUSH, DRAIN.
- IDLE:
  - cmd_ready=1, s_axis_tready=0.
  - On command handshake: latch width, offset, PRB count (0 maps to 256). Clear the PRB counter and beat counter. Go to RUN.
  - ud_iq_width and ctrl_fs_offset change only on this handshake.
- RUN:
  - cmd_ready=0; s_axis_tready = (credit != 0).
  - Each accepted beat registers din_data and asserts din_valid the next cycle (1-cycle latency).
  - din_state = beat counter; din_sync=1 when PRB=0 and beat=0.
  - Beat counter wraps BEATS_PER_PRB-1 → 0 and increments the PRB counter.
  - Final beat (last PRB, last beat):
    - din_last=1, state goes to DRAIN.
    - If s_axis_tlast=0 on this beat: pulse err_len and go to FLUSH instead.
  - Early end: s_axis_tlast=1 on any non-final beat. That beat is issued with din_last=1, err_len pulses, state goes to DRAIN.
- FLUSH:
  - s_axis_tready=1, din_valid=0; incoming beats are discarded.
  - On an accepted beat with tlast=1, go to DRAIN.
  - Discarded beats do not consume credit.
- DRAIN:
  - Counts PIPE_LAT+1 cycles after the last issued beat, then pulses done and returns to IDLE.
  - A new command is accepted only once back in IDLE.
- Credit counter, range 0..CREDITS:
  - Decrements on each beat issued in RUN; increments on credit_return.
  - Both in the same cycle: unchanged.
  - credit_return at credit=CREDITS is ignored (saturates).
  - Credit persists across sections and is not reset by IDLE.
- din_valid is 0 whenever no beat was accepted the previous cycle; din_sync and din_last are 0 when din_valid=0.
- Reset mid-section: everything returns to reset values the next cycle. In-flight datapath beats are not tracked. Upstream must also be reset.

Test Plan:
- Width 9, num_prb=2, 12 beats streamed, tlast on beat 12, credit_return tied 1 → din_state 0..5,0..5; din_sync on beat 1 only; din_last on beat 12; done 4 cycles after din_last; err_len never asserted.
- CREDITS=8, num_prb=2, credit_return=0 → exactly 8 beats issued, then s_axis_tready=0. One credit_return pulse → exactly 1 further beat.
- num_prb=1, tlast on beat 3 → beat 3 issued with din_state=2 and din_last=1; err_len pulses once; state goes to DRAIN, then done.
- num_prb=1, no tlast on beat 6, tlast on beat 9 → din_last on beat 6; err_len pulses; beats 7-9 accepted but din_valid=0; done after beat 9 plus drain.
- num_prb=0 → 1536 beats issued, din_last on the 1536th; cmd_iq_width change mid-section ignored (ud_iq_width stable).
- Reset asserted in RUN after beat 4 → next cycle all outputs at reset values, credit=CREDITS, cmd_ready=1.
